// File: rtl/areg_pkg.sv
// Shared types for the accumulating register bank: default width, sweep FSM
// states and the saturating-add helper used when AREG_SAT_EN is defined.
package areg_pkg;

  localparam int AREG_WIDTH = 32;
  localparam int SAT_MAXW   = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } clr_state_e;

  typedef struct packed {
    logic [SAT_MAXW-1:0] sum;
    logic                clamp;
  } sat_res_t;

  // Operands arrive sign-extended from a w-bit word (w < SAT_MAXW); the sum is
  // clamped to the signed w-bit range and the clamp flag reports it.
  function automatic sat_res_t sat_add(input logic signed [SAT_MAXW-1:0] a,
                                       input logic signed [SAT_MAXW-1:0] b,
                                       input int unsigned                w);
    logic signed [SAT_MAXW:0] s;
    logic signed [SAT_MAXW:0] one;
    logic signed [SAT_MAXW:0] hi;
    logic signed [SAT_MAXW:0] lo;
    sat_res_t r;
    one = 1;
    s   = $signed({a[SAT_MAXW-1], a}) + $signed({b[SAT_MAXW-1], b});
    hi  = (one <<< (w - 1)) - one;
    lo  = -hi - one;
    if (s > hi) begin
      r.sum   = hi[SAT_MAXW-1:0];
      r.clamp = 1'b1;
    end else if (s < lo) begin
      r.sum   = lo[SAT_MAXW-1:0];
      r.clamp = 1'b1;
    end else begin
      r.sum   = s[SAT_MAXW-1:0];
      r.clamp = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/areg_clr_seq.sv
// Bulk-clear sequencer: walks a pointer over every entry once per clr request,
// asserting busy/clr_we for exactly DEPTH cycles.
module areg_clr_seq
  import areg_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  output logic          busy,
  output logic [AW-1:0] ptr,
  output logic          clr_we
);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = SWEEP;
          ptr_d   = '0;
        end
      end
      SWEEP: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == AW'(DEPTH - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q == SWEEP);
  assign clr_we = (state_q == SWEEP);
  assign ptr    = ptr_q;

endmodule

// File: rtl/areg_bank.sv
// Multi-read-port accumulating register bank with optional low->high mirroring
// and a sequenced bulk clear. Define AREG_SAT_EN for saturating signed accumulate.
module areg_bank
  import areg_pkg::*;
#(
  parameter int WIDTH  = AREG_WIDTH,
  parameter int DEPTH  = 16,
  parameter int NRD    = 2,
  parameter int MIRROR = 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    ra,
  output logic [NRD*WIDTH-1:0] rval,
  input  logic                 w,
  input  logic                 y,
  input  logic [AW-1:0]        wa,
  input  logic [WIDTH-1:0]     wval,
  input  logic                 clr,
  output logic                 busy,
  output logic                 sat
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    ptr;
  logic             clr_we;
  logic             wr_acc;
  logic             sweep_start;
  logic             mirror_en;
  logic [AW-1:0]    mirror_addr;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] acc;
  logic             acc_clamp;
  logic [WIDTH-1:0] nval;
  logic [DEPTH-1:0] wr_hit;

  areg_clr_seq #(.DEPTH(DEPTH)) u_clr_seq (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .busy   (busy),
    .ptr    (ptr),
    .clr_we (clr_we)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      assign rval[gi*WIDTH +: WIDTH] = mem_q[ra[gi*AW +: AW]];
    end
  endgenerate

  assign wr_acc      = w && !busy;
  assign sweep_start = clr && !busy;
  assign mirror_en   = (MIRROR != 0) && !wa[AW-1];
  assign mirror_addr = wa | AW'(DEPTH / 2);
  // Accumulate always reads the addressed entry, never its mirror copy.
  assign cur         = mem_q[wa];

`ifdef AREG_SAT_EN
  sat_res_t sres;
  always_comb begin
    sres      = sat_add(SAT_MAXW'($signed(cur)), SAT_MAXW'($signed(wval)), WIDTH);
    acc       = sres.sum[WIDTH-1:0];
    acc_clamp = sres.clamp;
  end
`else
  assign acc       = cur + wval;
  assign acc_clamp = 1'b0;
`endif

  assign nval = y ? wval : acc;

  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_hit
      assign wr_hit[gi] = wr_acc &&
                          ((wa == AW'(gi)) || (mirror_en && (mirror_addr == AW'(gi))));
    end
  endgenerate

  // Sweep zeroing and accepted writes never collide: writes are dropped while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (clr_we && (ptr == AW'(i))) mem_q[i] <= '0;
        else if (wr_hit[i])            mem_q[i] <= nval;
      end
    end
  end

`ifdef AREG_SAT_EN
  logic sat_q;
  always_ff @(posedge clk) begin
    if (rst)                             sat_q <= 1'b0;
    else if (sweep_start)                sat_q <= 1'b0;
    else if (wr_acc && !y && acc_clamp)  sat_q <= 1'b1;
  end
  assign sat = sat_q;
`else
  assign sat = 1'b0;
  logic unused_ok;
  assign unused_ok = ^{sweep_start, acc_clamp};
`endif

endmodule
